reimu_bullet_ctrl: RTL



---
 rtl/reimu_bullet_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/reimu_bullet_ctrl.sv
// Player-shot controller: launches one bullet on a fire request, moves it up
// once per frame tick, despawns on hit or at the top edge, then cools down.
module reimu_bullet_ctrl #(
  parameter int unsigned SPEED     = 6,
  parameter int unsigned SPAWN_OFS = 33,
  parameter int unsigned Y_MIN     = 8,
  parameter int unsigned COOLDOWN  = 8,
  parameter int unsigned TICK_H    = 0,
  parameter int unsigned TICK_V    = 480
) (
  input  logic       clk_25m,
  input  logic       rst_n,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       fire,
  input  logic [9:0] reimux,
  input  logic [9:0] reimuy,
  input  logic       reimuE,
  input  logic       hit,
  output logic [9:0] reimu_bulletx,
  output logic [9:0] reimu_bullety,
  output logic       reimu_bullet
);

  localparam int unsigned POS_W = 10;
  localparam int unsigned CNT_W = 8;

  // Lowest player y that still leaves the spawned bullet on screen.
  localparam logic [POS_W-1:0] LAUNCH_MIN = POS_W'(SPAWN_OFS + Y_MIN);
  // Lowest bullet y that can still take a full step upward.
  localparam logic [POS_W-1:0] STEP_MIN   = POS_W'(Y_MIN + SPEED);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t           state;
  logic             fire_s1;
  logic             fire_s2;
  logic             fire_d;
  logic             pending;
  logic [CNT_W-1:0] cool_cnt;
  logic             tick;
  logic             fire_rise;

  // Frame tick marks the first blanking line; rising edge of synchronised fire.
  always_comb begin
    tick      = (hc == POS_W'(TICK_H)) && (vc == POS_W'(TICK_V));
    fire_rise = fire_s2 && !fire_d;
  end

  // Fire synchroniser, request latch and bullet FSM with registered outputs.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      fire_s1       <= 1'b0;
      fire_s2       <= 1'b0;
      fire_d        <= 1'b0;
      pending       <= 1'b0;
      cool_cnt      <= '0;
      reimu_bulletx <= '0;
      reimu_bullety <= '0;
      reimu_bullet  <= 1'b0;
    end else begin
      fire_s1 <= fire;
      fire_s2 <= fire_s1;
      fire_d  <= fire_s2;

      // A missing player cancels any request; later writes below override.
      if (!reimuE) begin
        pending <= 1'b0;
      end else if (fire_rise) begin
        pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (tick && pending && reimuE) begin
            pending <= 1'b0;
            if (reimuy >= LAUNCH_MIN) begin
              reimu_bulletx <= reimux;
              reimu_bullety <= reimuy - POS_W'(SPAWN_OFS);
              reimu_bullet  <= 1'b1;
              state         <= FLY;
            end
          end
        end
        FLY: begin
          if (hit) begin
            reimu_bullet <= 1'b0;
            cool_cnt     <= CNT_W'(COOLDOWN);
            state        <= COOL;
          end else if (tick) begin
            if (reimu_bullety >= STEP_MIN) begin
              reimu_bullety <= reimu_bullety - POS_W'(SPEED);
            end else begin
              reimu_bullet <= 1'b0;
              cool_cnt     <= CNT_W'(COOLDOWN);
              state        <= COOL;
            end
          end
        end
        COOL: begin
          if (tick) begin
            if (cool_cnt <= CNT_W'(1)) begin
              cool_cnt <= '0;
              state    <= IDLE;
            end else begin
              cool_cnt <= cool_cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
